// File: rtl/cpu_fwd_hazard_unit.sv
// ============================================================================
// Module   : cpu_fwd_hazard_unit
// Brief    : ID-stage operand bypass selection, load-use / RAW / WAW stall
//            detection and a countdown scoreboard for multi-cycle results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_W      = 3,
    parameter int LONG_LAT   = 4,
    parameter int ZERO_REG   = 1,
    localparam int SEL_W     = $clog2(NUM_STAGES + 1),
    localparam int NUM_REGS  = 2 ** REG_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_W-1:0]      src_addr_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    input  logic [NUM_STAGES*REG_W-1:0]   stage_rd_i,
    input  logic [NUM_STAGES-1:0]         stage_we_i,
    input  logic [NUM_STAGES-1:0]         stage_load_i,
    input  logic                          issue_valid_i,
    input  logic [REG_W-1:0]              issue_rd_i,
    input  logic                          issue_we_i,
    input  logic                          issue_long_i,
    input  logic                          flush_i,
    output logic [NUM_SRC*SEL_W-1:0]      bypass_sel_o,
    output logic                          stall_o,
    output logic [NUM_REGS-1:0]           busy_o
);

    localparam logic [3:0] c_long_lat = 4'(LONG_LAT);

    logic [3:0]          r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic                w_load_use;
    logic                w_raw;
    logic                w_waw;
    logic                w_stall;
    logic                w_arm;

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
            assign w_busy[r] = (r_cnt[r] != 4'd0);
        end
    endgenerate

    always_comb begin
        logic [REG_W-1:0] w_src;
        logic [SEL_W-1:0] w_sel_j;
        logic             w_zero;
        w_sel      = '0;
        w_load_use = 1'b0;
        w_raw      = 1'b0;
        w_src      = '0;
        w_sel_j    = '0;
        w_zero     = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_src   = src_addr_i[j*REG_W +: REG_W];
            w_zero  = (ZERO_REG != 0) && (w_src == '0);
            w_sel_j = '0;
            // Scan oldest to youngest so the youngest matching stage wins.
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (stage_we_i[k] && (stage_rd_i[k*REG_W +: REG_W] == w_src)) begin
                    w_sel_j = SEL_W'(k + 1);
                end
            end
            if (!src_valid_i[j] || w_zero) begin
                w_sel_j = '0;
            end
            for (int k = 0; k < NUM_STAGES; k++) begin
                if ((w_sel_j == SEL_W'(k + 1)) && stage_load_i[k]) begin
                    w_load_use = 1'b1;
                end
            end
            if (src_valid_i[j] && !w_zero && w_busy[w_src]) begin
                w_raw = 1'b1;
            end
            w_sel[j*SEL_W +: SEL_W] = w_sel_j;
        end
    end

    assign w_waw   = issue_valid_i && issue_we_i && w_busy[issue_rd_i];
    assign w_stall = w_load_use || w_raw || w_waw;
    assign w_arm   = issue_valid_i && !w_stall && issue_long_i && issue_we_i &&
                     !((ZERO_REG != 0) && (issue_rd_i == '0));

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= 4'd0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r_cnt[r] != 4'd0) begin
                    r_cnt[r] <= r_cnt[r] - 4'd1;
                end
            end
            // WAW stall guarantees the target entry is idle, so arming never races a decrement.
            if (w_arm) begin
                r_cnt[issue_rd_i] <= c_long_lat;
            end
        end
    end

    assign bypass_sel_o = w_sel;
    assign stall_o      = w_stall;
    assign busy_o       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fwd_hazard_unit.sv
// ============================================================================
// Module   : tb_cpu_fwd_hazard_unit
// Brief    : Directed vector table plus multi-cycle scoreboard sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_fwd_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] src_addr_i;
    logic [1:0] src_valid_i;
    logic [5:0] stage_rd_i;
    logic [1:0] stage_we_i;
    logic [1:0] stage_load_i;
    logic       issue_valid_i;
    logic [2:0] issue_rd_i;
    logic       issue_we_i;
    logic       issue_long_i;
    logic       flush_i;
    logic [3:0] bypass_sel_o;
    logic       stall_o;
    logic [7:0] busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0] src;
        logic [1:0] vld;
        logic [5:0] rd;
        logic [1:0] we;
        logic [1:0] ld;
        logic [3:0] exp_sel;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [10];

    cpu_fwd_hazard_unit dut (
        .clock         (clock),
        .reset         (reset),
        .src_addr_i    (src_addr_i),
        .src_valid_i   (src_valid_i),
        .stage_rd_i    (stage_rd_i),
        .stage_we_i    (stage_we_i),
        .stage_load_i  (stage_load_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_we_i    (issue_we_i),
        .issue_long_i  (issue_long_i),
        .flush_i       (flush_i),
        .bypass_sel_o  (bypass_sel_o),
        .stall_o       (stall_o),
        .busy_o        (busy_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        src_addr_i    = '0;
        src_valid_i   = '0;
        stage_rd_i    = '0;
        stage_we_i    = '0;
        stage_load_i  = '0;
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        issue_we_i    = 1'b0;
        issue_long_i  = 1'b0;
        flush_i       = 1'b0;
    endtask

    // Advance one clock and land just after the edge, ready to drive.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic long_issue(input logic [2:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        issue_we_i    = 1'b1;
        issue_long_i  = 1'b1;
    endtask

    initial begin
        //               src     vld    rd      we     ld     sel      stall
        vecs[0] = '{6'o03, 2'b01, 6'o33, 2'b11, 2'b00, 4'b0001, 1'b0};
        vecs[1] = '{6'o03, 2'b01, 6'o33, 2'b10, 2'b00, 4'b0010, 1'b0};
        vecs[2] = '{6'o03, 2'b11, 6'o30, 2'b11, 2'b01, 4'b0010, 1'b0};
        vecs[3] = '{6'o03, 2'b00, 6'o03, 2'b01, 2'b01, 4'b0000, 1'b0};
        vecs[4] = '{6'o05, 2'b01, 6'o05, 2'b01, 2'b01, 4'b0001, 1'b1};
        vecs[5] = '{6'o05, 2'b01, 6'o50, 2'b10, 2'b00, 4'b0010, 1'b0};
        vecs[6] = '{6'o05, 2'b01, 6'o55, 2'b11, 2'b10, 4'b0001, 1'b0};
        vecs[7] = '{6'o62, 2'b11, 6'o26, 2'b11, 2'b00, 4'b0110, 1'b0};
        vecs[8] = '{6'o27, 2'b10, 6'o20, 2'b10, 2'b10, 4'b1000, 1'b1};
        vecs[9] = '{6'o77, 2'b11, 6'o77, 2'b00, 2'b11, 4'b0000, 1'b0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        sample();
        check("reset_busy",  32'(busy_o),       32'h0);
        check("reset_sel",   32'(bypass_sel_o), 32'h0);
        check("reset_stall", 32'(stall_o),      32'h0);

        // Pure combinational bypass / load-use vectors (scoreboard idle).
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            src_addr_i   = vecs[i].src;
            src_valid_i  = vecs[i].vld;
            stage_rd_i   = vecs[i].rd;
            stage_we_i   = vecs[i].we;
            stage_load_i = vecs[i].ld;
            sample();
            check($sformatf("vec%0d_sel", i),   32'(bypass_sel_o), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_stall", i), 32'(stall_o),      32'(vecs[i].exp_stall));
        end

        // Long op to r4: busy for exactly LONG_LAT cycles, WAW issue mid-way must not re-arm.
        next_cycle();
        idle_inputs();
        long_issue(3'd4);
        sample();
        check("long4_issue_stall", 32'(stall_o), 32'h0);
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                long_issue(3'd4);
            end else begin
                src_addr_i  = 6'o04;
                src_valid_i = 2'b01;
            end
            sample();
            check($sformatf("long4_busy_c%0d", c),  32'(busy_o[4]), 32'h1);
            check($sformatf("long4_stall_c%0d", c), 32'(stall_o),   32'h1);
            next_cycle();
            idle_inputs();
        end
        src_addr_i  = 6'o04;
        src_valid_i = 2'b01;
        stage_rd_i  = 6'o04;
        stage_we_i  = 2'b01;
        sample();
        check("long4_done_busy",  32'(busy_o),       32'h0);
        check("long4_done_stall", 32'(stall_o),      32'h0);
        check("long4_done_sel",   32'(bypass_sel_o), 32'h1);

        // Long op to r0 is ignored when register 0 is hardwired zero.
        next_cycle();
        idle_inputs();
        long_issue(3'd0);
        next_cycle();
        idle_inputs();
        sample();
        check("long0_not_armed", 32'(busy_o), 32'h0);

        // Long op to r2, flush two cycles later together with a new long issue to r3.
        next_cycle();
        long_issue(3'd2);
        next_cycle();
        idle_inputs();
        sample();
        check("flush_pre_busy", 32'(busy_o), 32'h04);
        next_cycle();
        long_issue(3'd3);
        flush_i = 1'b1;
        next_cycle();
        idle_inputs();
        sample();
        check("flush_busy", 32'(busy_o), 32'h0);

        // Reset in the middle of a countdown on r6.
        next_cycle();
        long_issue(3'd6);
        next_cycle();
        idle_inputs();
        next_cycle();
        sample();
        check("rst_mid_busy_pre", 32'(busy_o), 32'h40);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset       = 1'b0;
        src_addr_i  = 6'o06;
        src_valid_i = 2'b01;
        sample();
        check("rst_mid_busy",  32'(busy_o),  32'h0);
        check("rst_mid_stall", 32'(stall_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
